// File: rtl/module_repeat_divider_pkg.sv
// Shared types and default widths for the repeated-subtraction divider.
// Also holds the small state-classification helper used by the control logic.
package module_repeat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } repdiv_state_t;

    localparam int REPDIV_TOTAL_W = 16;
    localparam int REPDIV_VAL_W   = 8;

    // A new request is only honoured while no division is in flight.
    function automatic logic is_accept_state(input repdiv_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/module_repeat_divider_if.sv
// Request/result bundle between a requester and the repeated-subtraction divider.
// The master drives the operands and start; the slave returns status and result.
interface module_repeat_divider_if
    import module_repeat_pkg::*;
#(
    parameter int TOTAL_W = REPDIV_TOTAL_W,
    parameter int VAL_W   = REPDIV_VAL_W
);

    logic               in_start;
    logic [TOTAL_W-1:0] in_total;
    logic [VAL_W-1:0]   in_sub_val;
    logic               out_busy;
    logic               out_done;
    logic [TOTAL_W-1:0] out_quotient;
    logic [VAL_W-1:0]   out_remainder;
    logic               out_div_by_zero;

    modport master (
        output in_start,
        output in_total,
        output in_sub_val,
        input  out_busy,
        input  out_done,
        input  out_quotient,
        input  out_remainder,
        input  out_div_by_zero
    );

    modport slave (
        input  in_start,
        input  in_total,
        input  in_sub_val,
        output out_busy,
        output out_done,
        output out_quotient,
        output out_remainder,
        output out_div_by_zero
    );

endinterface

// File: rtl/module_repeat_divider.sv
// Unsigned divider that recovers a repeat count from an accumulated total by
// subtracting the step value once per clock; returns quotient and remainder.
module module_repeat_divider
    import module_repeat_pkg::*;
#(
    parameter int TOTAL_W = REPDIV_TOTAL_W,
    parameter int VAL_W   = REPDIV_VAL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    module_repeat_divider_if.slave bus
);

    repdiv_state_t      state_r;
    repdiv_state_t      state_nxt_s;

    logic [TOTAL_W-1:0] rem_r;
    logic [TOTAL_W-1:0] quot_r;
    logic [VAL_W-1:0]   step_r;
    logic [TOTAL_W-1:0] quotient_r;
    logic [VAL_W-1:0]   remainder_r;
    logic               div_by_zero_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               step_zero_s;
    logic [TOTAL_W-1:0] step_ext_s;
    logic               fits_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;

    // Request acceptance and the compare that decides whether another subtraction fits.
    always_comb begin
        accept_s    = bus.in_start && is_accept_state(state_r);
        step_zero_s = (bus.in_sub_val == {VAL_W{1'b0}});
        step_ext_s  = {{(TOTAL_W-VAL_W){1'b0}}, step_r};
        fits_s      = (rem_r >= step_ext_s);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero step skips RUN and reports straight away.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = step_zero_s ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (fits_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Status flags decoded from the upcoming state so they can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            RUN:     busy_nxt_s = 1'b1;
            DONE:    done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand capture, iterative subtraction and result latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r         <= {TOTAL_W{1'b0}};
            quot_r        <= {TOTAL_W{1'b0}};
            step_r        <= {VAL_W{1'b0}};
            quotient_r    <= {TOTAL_W{1'b0}};
            remainder_r   <= {VAL_W{1'b0}};
            div_by_zero_r <= 1'b0;
        end else if (accept_s) begin
            rem_r         <= bus.in_total;
            step_r        <= bus.in_sub_val;
            quot_r        <= {TOTAL_W{1'b0}};
            div_by_zero_r <= step_zero_s;
            if (step_zero_s) begin
                quotient_r  <= {TOTAL_W{1'b1}};
                remainder_r <= {VAL_W{1'b0}};
            end
        end else if (state_r == RUN) begin
            if (fits_s) begin
                rem_r  <= rem_r - step_ext_s;
                quot_r <= quot_r + {{(TOTAL_W-1){1'b0}}, 1'b1};
            end else begin
                // rem is below step here, so its low VAL_W bits hold it exactly.
                quotient_r  <= quot_r;
                remainder_r <= rem_r[VAL_W-1:0];
            end
        end
    end

    assign bus.out_busy        = busy_r;
    assign bus.out_done        = done_r;
    assign bus.out_quotient    = quotient_r;
    assign bus.out_remainder   = remainder_r;
    assign bus.out_div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_module_repeat_divider.sv
// Bench for the repeated-subtraction divider: directed corner cases plus
// random operands compared against plain integer division.
module tb_module_repeat_divider;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    module_repeat_divider_if #(.TOTAL_W(16), .VAL_W(8)) bus ();

    module_repeat_divider #(.TOTAL_W(16), .VAL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble operands to catch re-sampling.
    task automatic launch(input logic [15:0] t, input logic [7:0] v);
        bus.in_start   = 1'b1;
        bus.in_total   = t;
        bus.in_sub_val = v;
        step();
        bus.in_start   = 1'b0;
        bus.in_total   = 16'($urandom);
        bus.in_sub_val = 8'($urandom);
    endtask

    // Wait for the done pulse and compare against integer division of the operands.
    task automatic collect(input logic [15:0] t, input logic [7:0] v, input int inject_at);
        int   busy_cnt;
        logic seen;
        int   exp_q, exp_r, exp_z, exp_busy;
        busy_cnt = 0;
        seen     = 1'b0;
        if (v == 8'd0) begin
            exp_q = 32'hFFFF; exp_r = 0; exp_z = 1; exp_busy = 0;
        end else begin
            exp_q = int'(t) / int'(v);
            exp_r = int'(t) % int'(v);
            exp_z = 0;
            exp_busy = exp_q + 1;
        end
        for (int cyc = 0; cyc < 70000; cyc++) begin
            if (bus.out_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.out_busy) busy_cnt++;
            bus.in_start = (cyc == inject_at);
            if (cyc == inject_at) begin
                bus.in_total   = 16'($urandom);
                bus.in_sub_val = 8'($urandom_range(1, 255));
            end
            step();
        end
        bus.in_start = 1'b0;
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("busy_at_done", 32'(bus.out_busy), 32'd0);
        check_val("quotient", 32'(bus.out_quotient), exp_q);
        check_val("remainder", 32'(bus.out_remainder), exp_r);
        check_val("div_by_zero", 32'(bus.out_div_by_zero), exp_z);
        check_val("busy_cycles", busy_cnt, exp_busy);
    endtask

    // The done flag must drop after one cycle while results hold.
    task automatic end_pulse();
        logic [15:0] q;
        logic [7:0]  r;
        q = bus.out_quotient;
        r = bus.out_remainder;
        step();
        check_val("done_pulse_len", 32'(bus.out_done), 32'd0);
        check_val("hold_quotient", 32'(bus.out_quotient), 32'(q));
        check_val("hold_remainder", 32'(bus.out_remainder), 32'(r));
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_busy"}, 32'(bus.out_busy), 32'd0);
        check_val({tag, "_done"}, 32'(bus.out_done), 32'd0);
        check_val({tag, "_quot"}, 32'(bus.out_quotient), 32'd0);
        check_val({tag, "_rem"}, 32'(bus.out_remainder), 32'd0);
        check_val({tag, "_dbz"}, 32'(bus.out_div_by_zero), 32'd0);
    endtask

    initial begin
        logic [15:0] t;
        logic [7:0]  v;
        int          done_cnt;

        rst            = 1'b1;
        bus.in_start   = 1'b0;
        bus.in_total   = 16'd0;
        bus.in_sub_val = 8'd0;
        repeat (2) step();
        check_cleared("reset");
        rst = 1'b0;
        step();

        launch(16'd100, 8'd7);     collect(16'd100, 8'd7, -1);     end_pulse();
        launch(16'd1000, 8'd200);  collect(16'd1000, 8'd200, -1);  end_pulse();
        launch(16'd5, 8'd9);       collect(16'd5, 8'd9, -1);       end_pulse();
        launch(16'd0, 8'd3);       collect(16'd0, 8'd3, -1);       end_pulse();
        launch(16'd1234, 8'd0);    collect(16'd1234, 8'd0, -1);    end_pulse();
        launch(16'hFFFF, 8'hFF);   collect(16'hFFFF, 8'hFF, -1);   end_pulse();

        // A start pulsed mid-run must not disturb the running division.
        launch(16'd100, 8'd7);     collect(16'd100, 8'd7, 3);      end_pulse();

        // Start issued in the done cycle chains straight into the next division.
        launch(16'd1000, 8'd200);  collect(16'd1000, 8'd200, -1);
        launch(16'd30, 8'd4);
        check_val("chain_busy", 32'(bus.out_busy), 32'd1);
        collect(16'd30, 8'd4, -1);
        end_pulse();

        // Reset mid-run clears everything immediately and suppresses done.
        launch(16'd1000, 8'd7);
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_cleared("midrun_reset");
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_done) done_cnt++;
            step();
        end
        check_val("no_done_after_reset", done_cnt, 0);
        check_cleared("after_reset");

        for (int i = 0; i < 30; i++) begin
            t = 16'($urandom_range(0, 4000));
            v = (i % 7 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            launch(t, v);
            collect(t, v, (i % 3 == 0) ? 2 : -1);
            if (i % 2 == 0) end_pulse();
        end
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
